uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-parallel UART receiver: the receive end of the team's UART transmitter link. It recovers start / 8 data (LSB first) / optional parity / stop frames from a single serial line and presents each byte with a one-cycle valid strobe plus parity and stop error flags. It runs in the transmitter's clock domain with matching frame format and parity convention, so a transmitter output can be looped directly into it.

## Interface
- CLKS_PER_BIT, default 1: clock cycles per serial bit. 1 matches the transmitter (one bit per clock). Must be ≥1.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line; idles high. Same clock domain, no synchronizer.
- PAR_EN  in  1  1 = a parity bit follows the data bits.
- PAR_TYP  in  1  0 = odd parity (expected bit = ~^data); 1 = even parity (expected bit = ^data).
- P_DATA  out  8  last received byte.
- DATA_VALID  out  1  one-cycle strobe: frame completed, P_DATA updated.
- PAR_ERR  out  1  qualifies DATA_VALID: received parity ≠ expected.
- STOP_ERR  out  1  qualifies DATA_VALID: stop bit sampled low.
- Busy  out  1  high while a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- H = (CLKS_PER_BIT-1)/2 (integer division) is the mid-bit offset. Clock counter is $clog2(CLKS_PER_BIT)+1 bits wide. Bit counter is 3 bits, counting 0..7.
- IDLE: RX_IN==0 sampled at edge t0 is a start detect. On a start detect, latch PAR_EN and PAR_TYP, clear the clock counter, set Busy=1, and go to START.
- START: at edge t0+H, re-sample RX_IN.
  - If 0: clear counters and go to DATA.
  - If 1 (glitch): go to IDLE, Busy=0, no strobe.
  - When H==0, the start detect itself is the mid-sample and the FSM enters DATA directly from IDLE.
- DATA: data bit i is sampled at edge t0+H+CLKS_PER_BIT·(i+1) into shift-register bit i (LSB first). After bit 7, go to PARITY if the latched PAR_EN is 1, otherwise go to STOP.
- PARITY: sample one bit period after bit 7. The expected bit is computed from the received byte with the latched PAR_TYP. Store the mismatch.
- STOP: sample one bit period after the last data or parity bit. At this edge:
  - P_DATA ← shift register.
  - DATA_VALID ← 1.
  - PAR_ERR ← stored mismatch (0 if parity disabled).
  - STOP_ERR ← ~RX_IN.
  - Next state: IDLE if RX_IN==1, otherwise BREAK.
  - Busy ← 0 in both cases.
- BREAK: stay until RX_IN==1 is sampled, then go to IDLE. No start detection while in BREAK. Busy=0.
- A frame with errors is still delivered. DATA_VALID pulses for every frame that reaches STOP.
- P_DATA holds its value between strobes. PAR_ERR and STOP_ERR are valid only in the DATA_VALID cycle and are 0 otherwise.

## Timing
- Reset (asynchronous, any time, including mid-frame): state=IDLE, counters=0, P_DATA=8'h00, DATA_VALID=0, PAR_ERR=0, STOP_ERR=0, Busy=0. A frame that is partially received when reset asserts is discarded; no strobe is issued.
- All outputs are registered.
- Busy rises in the cycle after the start-detect edge. It falls in the cycle after the stop-sample edge, which is the same cycle DATA_VALID is high.
- With CLKS_PER_BIT=1, if the first start bit is present on RX_IN before edge t0:
  - DATA_VALID is high for the cycle after edge t0+9 (no parity) or edge t0+10 (parity).
  - Busy is high for 9 cycles (no parity) or 10 cycles (parity).
- Back-to-back frames: the FSM is in IDLE immediately after the stop-sample edge, so a new start detect is possible on the next edge. This covers the transmitter's single idle cycle between frames.
- PAR_EN and PAR_TYP changes during a frame have no effect until the next start detect.

## Test plan
- CLKS_PER_BIT=1, PAR_EN=0: drive 1, then 0, then bits 0,0,1,1,1,1,0,0, then 1 (0x3C). Required: DATA_VALID high for exactly one cycle, P_DATA=8'h3C, PAR_ERR=0, STOP_ERR=0, Busy high for 9 cycles.
- PAR_EN=1, PAR_TYP=0, byte 0xA5 with parity bit 1. Required: P_DATA=8'hA5, PAR_ERR=0.
  - Repeat with parity bit 0. Required: PAR_ERR=1, DATA_VALID still pulses.
  - Repeat with PAR_TYP=1 and parity bit 0. Required: PAR_ERR=0.
- PAR_EN=0, byte 0x81 with the stop bit 0, then hold RX_IN low for 5 cycles, then high. Required: one strobe with STOP_ERR=1 and P_DATA=8'h81; no further strobe while the line is low. The next valid 0x55 frame is received cleanly.
- Transmitter looped back into the receiver, sending 0x12 then 0xEF with PAR_EN=1 and PAR_TYP=1. Required: two strobes with 0x12 then 0xEF, and no errors.
- Reset pulsed low during data bit 3 of a 0xFF frame. Required: all outputs 0 immediately; no strobe for the aborted frame. The following 0x0F frame is received correctly.
- CLKS_PER_BIT=4:
  - RX_IN low for 1 cycle only (glitch). Required: Busy drops back to 0 and no strobe.
  - A full 0xC3 frame, each bit held for 4 cycles. Required: P_DATA=8'hC3, with each sample taken 1 cycle after its bit edge.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: start / 8 data bits (LSB first) / optional parity / stop.
// Each bit is sampled at its middle, and every completed frame produces a one-cycle DATA_VALID strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       DATA_VALID,
  output logic       PAR_ERR,
  output logic       STOP_ERR,
  output logic       Busy
);

  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] MID_M1 = (H > 0) ? CW'(H - 1) : '0;
  localparam logic [CW-1:0] BIT_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par_en, r_par_typ, r_par_miss;
  logic            w_mid, w_tick, w_exp_par;

  // The counter restarts at every sample point, so one compare value
  // serves as the bit-period tick in all of the bit states.
  assign w_mid     = (r_clk_cnt == MID_M1);
  assign w_tick    = (r_clk_cnt == BIT_M1);
  assign w_exp_par = r_par_typ ? ^r_shift : ~^r_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!RX_IN) w_next = (H == 0) ? DATA : START;
      START:   if (w_mid) w_next = RX_IN ? IDLE : DATA;
      DATA:    if (w_tick && r_bit_cnt == 3'd7) w_next = r_par_en ? PARITY : STOP;
      PARITY:  if (w_tick) w_next = STOP;
      STOP:    if (w_tick) w_next = RX_IN ? IDLE : BREAK;
      BREAK:   if (RX_IN) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_par_miss <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STOP_ERR   <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STOP_ERR   <= 1'b0;
      Busy       <= (w_next == START) || (w_next == DATA) ||
                    (w_next == PARITY) || (w_next == STOP);
      r_clk_cnt  <= r_clk_cnt + CW'(1);
      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (!RX_IN) begin
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_miss <= 1'b0;
          end
        end
        START: if (w_mid) r_clk_cnt <= '0;
        DATA: if (w_tick) begin
          r_shift[r_bit_cnt] <= RX_IN;
          r_bit_cnt          <= r_bit_cnt + 3'd1;
          r_clk_cnt          <= '0;
        end
        PARITY: if (w_tick) begin
          r_par_miss <= (RX_IN != w_exp_par);
          r_clk_cnt  <= '0;
        end
        STOP: if (w_tick) begin
          P_DATA     <= r_shift;
          DATA_VALID <= 1'b1;
          PAR_ERR    <= r_par_en & r_par_miss;
          STOP_ERR   <= ~RX_IN;
          r_clk_cnt  <= '0;
        end
        default: r_clk_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver at 1 clock per bit, a second at 4 clocks per bit.
// Frames are built by a serial driver that mimics the transmitter's line timing.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx1 = 1'b1, rx4 = 1'b1;
  logic       par_en = 1'b0, par_typ = 1'b0;
  logic [7:0] pd1, pd4;
  logic       dv1, pe1, se1, busy1;
  logic       dv4, pe4, se4, busy4;

  int n_chk = 0, n_fail = 0;

  // strobe / busy bookkeeping for each receiver
  int         str1 = 0, busy1_cyc = 0, err1 = 0;
  logic [7:0] q1 [$];
  logic       last_pe1, last_se1;
  int         str4 = 0, busy4_cyc = 0;
  logic [7:0] last_d4;
  logic       last_pe4, last_se4;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(rst_n), .RX_IN(rx1), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .P_DATA(pd1), .DATA_VALID(dv1), .PAR_ERR(pe1), .STOP_ERR(se1), .Busy(busy1));

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(rst_n), .RX_IN(rx4), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .P_DATA(pd4), .DATA_VALID(dv4), .PAR_ERR(pe4), .STOP_ERR(se4), .Busy(busy4));

  always @(negedge clk) begin
    if (busy1) busy1_cyc++;
    if (busy4) busy4_cyc++;
    if (dv1) begin
      str1++;
      q1.push_back(pd1);
      last_pe1 = pe1;
      last_se1 = se1;
      if (pe1 || se1) err1++;
    end
    if (dv4) begin
      str4++;
      last_d4  = pd4;
      last_pe4 = pe4;
      last_se4 = se4;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    str1 = 0; busy1_cyc = 0; err1 = 0; q1.delete();
    str4 = 0; busy4_cyc = 0;
  endtask

  // hold a level on one receiver's line for n clock edges
  task automatic drv(input bit sel4, input logic b, input int n);
    if (sel4) rx4 = b; else rx1 = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit sel4, input logic [7:0] d, input bit pen,
                       input logic pbit, input logic stop);
    int n;
    n = sel4 ? 4 : 1;
    drv(sel4, 1'b0, n);
    for (int i = 0; i < 8; i++) drv(sel4, d[i], n);
    if (pen) drv(sel4, pbit, n);
    drv(sel4, stop, n);
  endtask

  initial begin
    #3;
    check("reset P_DATA", {24'd0, pd1}, 32'h00);
    check("reset DATA_VALID", {31'd0, dv1}, 32'd0);
    check("reset Busy", {31'd0, busy1}, 32'd0);
    check("reset PAR_ERR", {31'd0, pe1}, 32'd0);
    check("reset STOP_ERR", {31'd0, se1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(0, 1'b1, 3);

    // 0x3C, no parity
    clr();
    frame(0, 8'h3C, 0, 1'b0, 1'b1);
    drv(0, 1'b1, 3);
    check("3C strobes", str1, 1);
    check("3C data", {24'd0, q1[0]}, 32'h3C);
    check("3C par_err", {31'd0, last_pe1}, 32'd0);
    check("3C stop_err", {31'd0, last_se1}, 32'd0);
    check("3C busy cycles", busy1_cyc, 9);
    check("P_DATA holds", {24'd0, pd1}, 32'h3C);

    // 0xA5 with odd parity, good parity bit
    par_en = 1'b1; par_typ = 1'b0;
    clr();
    frame(0, 8'hA5, 1, 1'b1, 1'b1);
    drv(0, 1'b1, 3);
    check("A5 odd ok strobes", str1, 1);
    check("A5 odd ok data", {24'd0, q1[0]}, 32'hA5);
    check("A5 odd ok par_err", {31'd0, last_pe1}, 32'd0);
    check("A5 busy cycles", busy1_cyc, 10);

    clr();
    frame(0, 8'hA5, 1, 1'b0, 1'b1);
    drv(0, 1'b1, 3);
    check("A5 odd bad strobes", str1, 1);
    check("A5 odd bad par_err", {31'd0, last_pe1}, 32'd1);
    check("A5 odd bad stop_err", {31'd0, last_se1}, 32'd0);

    par_typ = 1'b1;
    clr();
    frame(0, 8'hA5, 1, 1'b0, 1'b1);
    drv(0, 1'b1, 3);
    check("A5 even ok strobes", str1, 1);
    check("A5 even ok par_err", {31'd0, last_pe1}, 32'd0);

    // stop error into a held-low line, then recovery
    par_en = 1'b0;
    clr();
    frame(0, 8'h81, 0, 1'b0, 1'b0);
    drv(0, 1'b0, 5);
    check("81 strobes during break", str1, 1);
    check("81 data", {24'd0, q1[0]}, 32'h81);
    check("81 stop_err", {31'd0, last_se1}, 32'd1);
    check("busy in break", {31'd0, busy1}, 32'd0);
    drv(0, 1'b1, 2);
    frame(0, 8'h55, 0, 1'b0, 1'b1);
    drv(0, 1'b1, 3);
    check("55 strobes", str1, 2);
    check("55 data", {24'd0, q1[1]}, 32'h55);
    check("55 stop_err", {31'd0, last_se1}, 32'd0);

    // transmitter-style back-to-back frames, even parity, one idle cycle between
    par_en = 1'b1; par_typ = 1'b1;
    clr();
    frame(0, 8'h12, 1, 1'b0, 1'b1);
    drv(0, 1'b1, 1);
    frame(0, 8'hEF, 1, 1'b1, 1'b1);
    drv(0, 1'b1, 3);
    check("loop strobes", str1, 2);
    check("loop byte0", {24'd0, q1[0]}, 32'h12);
    check("loop byte1", {24'd0, q1[1]}, 32'hEF);
    check("loop errors", err1, 0);

    // reset in the middle of data bit 3 of 0xFF
    par_en = 1'b0;
    clr();
    drv(0, 1'b0, 1);
    for (int i = 0; i < 3; i++) drv(0, 1'b1, 1);
    rx1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid reset P_DATA", {24'd0, pd1}, 32'h00);
    check("mid reset Busy", {31'd0, busy1}, 32'd0);
    check("mid reset DATA_VALID", {31'd0, dv1}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    drv(0, 1'b1, 8);
    check("aborted frame strobes", str1, 0);
    frame(0, 8'h0F, 0, 1'b0, 1'b1);
    drv(0, 1'b1, 3);
    check("0F strobes", str1, 1);
    check("0F data", {24'd0, q1[0]}, 32'h0F);

    // 4 clocks per bit: one-cycle glitch, then a full frame
    clr();
    drv(1, 1'b0, 1);
    drv(1, 1'b1, 8);
    check("glitch busy cycles", busy4_cyc, 1);
    check("glitch busy now", {31'd0, busy4}, 32'd0);
    check("glitch strobes", str4, 0);
    clr();
    frame(1, 8'hC3, 0, 1'b0, 1'b1);
    drv(1, 1'b1, 6);
    check("C3 strobes", str4, 1);
    check("C3 data", {24'd0, last_d4}, 32'hC3);
    check("C3 par_err", {31'd0, last_pe4}, 32'd0);
    check("C3 stop_err", {31'd0, last_se4}, 32'd0);
    check("C3 no strobe on dut1", str1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
